// File: rtl/noc_tb_pkg.sv
// Shared definitions for the NoC traffic processing element: mode codes, FSM
// states, LFSR feedback taps and packet field offset helpers.
package noc_tb_pkg;

    typedef enum logic [2:0] {
        MODE_RANDOM    = 3'd0,
        MODE_SELF      = 3'd1,
        MODE_RIGHT     = 3'd2,
        MODE_TOP       = 3'd3,
        MODE_MIXED     = 3'd4,
        MODE_TRANSPOSE = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_SEND,
        ST_DONE
    } state_e;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int dest_y_lsb(input int dest_x);
        return dest_x;
    endfunction

    function automatic int src_x_lsb(input int dest_x, input int dest_y);
        return dest_x + dest_y;
    endfunction

    function automatic int src_y_lsb(input int dest_x, input int dest_y, input int source_x);
        return dest_x + dest_y + source_x;
    endfunction

    function automatic int payload_lsb(input int dest_x, input int dest_y,
                                       input int source_x, input int source_y);
        return dest_x + dest_y + source_x + source_y;
    endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR; reset reloads the seed, one shift per advance pulse.
module noc_lfsr16
    import noc_tb_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            value <= seed;
        else if (advance)
            value <= {value[14:0], ^(value & LFSR_TAPS)};
    end

endmodule

// File: rtl/noc_traffic_pe.sv
// Traffic-generating mesh PE: emits NUM_OF_PCKTS packets per enable session at
// most one every RATE cycles, and counts/validates packets it receives.
module noc_traffic_pe
    import noc_tb_pkg::*;
#(
    parameter int XCORD        = 0,
    parameter int YCORD        = 0,
    parameter int X            = 4,
    parameter int Y            = 4,
    parameter int DEST_X       = 2,
    parameter int DEST_Y       = 2,
    parameter int SOURCE_X     = 8,
    parameter int SOURCE_Y     = 8,
    parameter int DATA_WIDTH   = 240,
    parameter int NUM_OF_PCKTS = 3,
    parameter int RATE         = 1,
    localparam int TOTAL_WIDTH = DEST_X + DEST_Y + SOURCE_X + SOURCE_Y + DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [2:0]             i_mode,
    input  logic                   i_enable,
    output logic [TOTAL_WIDTH-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    input  logic [TOTAL_WIDTH-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_done,
    output logic [31:0]            o_tx_count,
    output logic [31:0]            o_rx_count,
    output logic                   o_rx_err
);

    localparam int DY_LSB = dest_y_lsb(DEST_X);
    localparam int SX_LSB = src_x_lsb(DEST_X, DEST_Y);
    localparam int SY_LSB = src_y_lsb(DEST_X, DEST_Y, SOURCE_X);
    localparam int PL_LSB = payload_lsb(DEST_X, DEST_Y, SOURCE_X, SOURCE_Y);

    localparam logic [15:0]       SEED    = 16'(YCORD * X + XCORD + 1);
    localparam logic [DEST_X-1:0] OWN_X   = DEST_X'(XCORD);
    localparam logic [DEST_Y-1:0] OWN_Y   = DEST_Y'(YCORD);
    localparam logic [DEST_X-1:0] RIGHT_X = DEST_X'((XCORD + 1) % X);
    localparam logic [DEST_Y-1:0] TOP_Y   = DEST_Y'((YCORD + 1) % Y);

    state_e                  state, state_nxt;
    logic [31:0]             gap_cnt, gap_nxt, seq, pkt_seq;
    logic                    accept, build, tx_last, tx_clr;
    logic [15:0]             lfsr_val;
    logic [DEST_X-1:0]       dx;
    logic [DEST_Y-1:0]       dy;
    logic [TOTAL_WIDTH-1:0]  pkt;
    logic                    unused_bits;

    assign o_valid     = (state == ST_SEND);
    assign o_done      = (state == ST_DONE);
    assign accept      = o_valid && i_ready;
    assign tx_last     = ({1'b0, o_tx_count} + 33'd1) >= 33'(NUM_OF_PCKTS);
    assign unused_bits = ^{i_data[TOTAL_WIDTH-1:SX_LSB], lfsr_val};

    noc_lfsr16 u_lfsr (
        .clk    (clk),
        .rstn   (rstn),
        .seed   (SEED),
        .advance(build),
        .value  (lfsr_val)
    );

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        build     = 1'b0;
        tx_clr    = 1'b0;
        case (state)
            ST_IDLE: if (i_enable) begin
                state_nxt = ST_GAP;
                gap_nxt   = 32'(RATE - 1);
            end
            ST_GAP: begin
                if (!i_enable)
                    state_nxt = ST_IDLE;
                else if (gap_cnt == '0) begin
                    build     = 1'b1;
                    state_nxt = ST_SEND;
                end else
                    gap_nxt = gap_cnt - 32'd1;
            end
            ST_SEND: if (i_ready) begin
                if (tx_last)
                    state_nxt = ST_DONE;
                else if (!i_enable)
                    state_nxt = ST_IDLE;
                else if (RATE == 1)
                    build = 1'b1;
                else begin
                    // The acceptance cycle counts as one of the RATE cycles.
                    state_nxt = ST_GAP;
                    gap_nxt   = 32'(RATE > 1 ? RATE - 2 : 0);
                end
            end
            ST_DONE: if (!i_enable) begin
                state_nxt = ST_IDLE;
                tx_clr    = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dx = OWN_X;
        dy = OWN_Y;
        case (i_mode)
            MODE_RANDOM: begin
                dx = lfsr_val[DEST_X-1:0];
                dy = lfsr_val[DY_LSB +: DEST_Y];
            end
            MODE_RIGHT: dx = RIGHT_X;
            MODE_TOP:   dy = TOP_Y;
            MODE_MIXED: if (lfsr_val[DEST_X+DEST_Y]) dy = TOP_Y;
                        else dx = RIGHT_X;
            MODE_TRANSPOSE: begin
                dx = DEST_X'(YCORD);
                dy = DEST_Y'(XCORD);
            end
            default: ;
        endcase
        // A back-to-back packet is built in the cycle its predecessor is accepted.
        pkt_seq = accept ? seq + 32'd1 : seq;
        pkt = '0;
        pkt[DEST_X-1:0]          = dx;
        pkt[DY_LSB +: DEST_Y]    = dy;
        pkt[SX_LSB +: SOURCE_X]  = SOURCE_X'(XCORD);
        pkt[SY_LSB +: SOURCE_Y]  = SOURCE_Y'(YCORD);
        pkt[PL_LSB +: DATA_WIDTH] = DATA_WIDTH'(pkt_seq);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            seq        <= '0;
            o_data     <= '0;
            o_tx_count <= '0;
            o_rx_count <= '0;
            o_rx_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            if (build)
                o_data <= pkt;
            if (accept)
                seq <= seq + 32'd1;
            if (tx_clr)
                o_tx_count <= '0;
            else if (accept && o_tx_count != '1)
                o_tx_count <= o_tx_count + 32'd1;
            if (i_valid && o_rx_count != '1)
                o_rx_count <= o_rx_count + 32'd1;
            if (i_valid && (i_data[DEST_X-1:0] != OWN_X || i_data[DY_LSB +: DEST_Y] != OWN_Y))
                o_rx_err <= 1'b1;
        end
    end

endmodule

// File: doc/noc_traffic_pe.md
NOC_TRAFFIC_PE -- requirements
Module: noc_traffic_pe

Interface
REQ-001 SHALL have parameter XCORD, default 0, own x coordinate.
REQ-002 SHALL have parameter YCORD, default 0, own y coordinate.
REQ-003 SHALL have parameters X, Y, default 4, 4, mesh size; both powers of two, at least 2.
REQ-004 SHALL have parameters DEST_X, DEST_Y, default 2, 2, destination field widths, equal to log2(X) and log2(Y).
REQ-005 SHALL have parameters SOURCE_X, SOURCE_Y, default 8, 8, source field widths.
REQ-006 SHALL have parameter DATA_WIDTH, default 240, payload width; TOTAL_WIDTH = DEST_X+DEST_Y+SOURCE_X+SOURCE_Y+DATA_WIDTH.
REQ-007 SHALL have parameter NUM_OF_PCKTS, default 3, packets to send per enable session.
REQ-008 SHALL have parameter RATE, default 1, minimum cycles between packet generations; at least 1.
REQ-009 SHALL have ports: clk in 1, clock. rstn in 1, reset, asynchronous, active-low.
REQ-010 SHALL have ports: i_mode in 3, traffic pattern. i_enable in 1, session enable.
REQ-011 SHALL have ports: o_data out TOTAL_WIDTH, packet. o_valid out 1. i_ready in 1.
REQ-012 SHALL have ports: i_data in TOTAL_WIDTH, received packet. i_valid in 1.
REQ-013 SHALL have ports: o_done out 1. o_tx_count out 32. o_rx_count out 32. o_rx_err out 1, sticky misroute flag.

Function
REQ-014 Packet layout SHALL be, from LSB: dest x, dest y, src x (XCORD), src y (YCORD), payload = tx sequence number, zero-extended or truncated to DATA_WIDTH.
REQ-015 Modes SHALL be: 0 RANDOM, 1 SELF, 2 RIGHT (x+1 mod X, same y), 3 TOP (y+1 mod Y, same x), 4 MIXED (LFSR bit DEST_X+DEST_Y: 0 selects RIGHT, 1 selects TOP), 5 TRANSPOSE (dest = (YCORD, XCORD), legal only when X==Y). Codes 6-7 SHALL behave as SELF.
REQ-016 RANDOM SHALL take dest x = LFSR[DEST_X-1:0] and dest y = LFSR[DEST_X+DEST_Y-1:DEST_X].
REQ-017 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, seeded YCORD*X+XCORD+1, advancing exactly once per generated packet.
REQ-018 FSM states SHALL be IDLE, GAP, SEND, DONE.
REQ-019 IDLE to GAP when i_enable=1; the gap counter loads RATE-1.
REQ-020 GAP SHALL decrement each cycle; at 0 it builds the packet (i_mode sampled this cycle) into o_data and moves to SEND.
REQ-021 In SEND, o_valid=1 and o_data SHALL stay stable until i_ready=1; acceptance increments o_tx_count.
REQ-022 On acceptance, if the tx count reaches NUM_OF_PCKTS, the FSM SHALL move to DONE; otherwise to GAP. With RATE=1 it SHALL go straight back to SEND with the next packet, sustaining one packet per cycle.
REQ-023 i_enable=0 in GAP SHALL return to IDLE. i_enable=0 in SEND SHALL not drop the packet: it is held until accepted, then the FSM goes to IDLE.
REQ-024 DONE SHALL assert o_done, hold o_valid=0, and return to IDLE, clearing the session tx count, only when i_enable=0.
REQ-025 o_rx_count SHALL increment every cycle with i_valid=1. o_rx_err SHALL set when a valid i_data dest field differs from (XCORD, YCORD).
REQ-026 Both counters SHALL saturate at 2^32-1.
REQ-027 Sequence number SHALL be 32-bit, increment per acceptance, and never clear except on reset.

Reset
REQ-028 On rstn=0, asynchronously: FSM IDLE, o_valid 0, o_data 0, o_done 0, counters 0, o_rx_err 0, LFSR reloaded with seed.
REQ-029 Reset mid-SEND SHALL drop the pending packet; no counter increments for it.

Structure
REQ-030 Package noc_tb_pkg SHALL hold the mode encodings, LFSR taps, and field-offset helpers.
REQ-031 The LFSR SHALL be a sub-module, noc_lfsr16, with ports clk, rstn, seed, advance, and value.

Verification
REQ-032 XCORD=1, YCORD=2, mode 2, RATE=1, i_ready=1 -> three packets on consecutive cycles, dest (2,2), payloads 0,1,2; then o_done=1 and o_tx_count=3.
REQ-033 XCORD=3, YCORD=3, mode 3, RATE=4 -> dest (3,0); o_valid rising edges exactly 4 cycles apart.
REQ-034 i_ready held 0 for 10 cycles in SEND -> o_data unchanged and o_valid=1 throughout; tx count increments once on release.
REQ-035 mode 0, seed PE 0 -> dest sequence matches a reference LFSR model over 100 packets, with NUM_OF_PCKTS=100.
REQ-036 i_valid carrying dest (0,1) into PE (1,0) -> o_rx_err=1 and o_rx_count=1; o_rx_err stays set afterward.
REQ-037 rstn pulsed low mid-SEND -> o_valid=0 asynchronously; counters 0; the next session restarts the LFSR sequence from the seed.
